axis_trailer_appender: RTL and testbench
========================================

Name: axis_trailer_appender

Overview:
- Downstream neighbour of axi_stream_processor. Consumes its AXI-Stream output packets and forwards every data beat unchanged.
- After each packet it appends one trailer beat carrying the packet's kept-byte count and a 16-bit modular byte checksum.
- A bypass input disables the trailer per packet.
- Feeds the link/DMA egress stage.

Parameters:
- TDATA_WIDTH, 32, data width in bits; multiple of 8, >= 32.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  TDATA_WIDTH  input beat data; byte i = bits [8i+7:8i].
- s_axis_tkeep  in  TDATA_WIDTH/8  byte qualifiers; bit i qualifies byte i.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  TDATA_WIDTH  output data.
- m_axis_tkeep  out  TDATA_WIDTH/8  output byte qualifiers.
- m_axis_tlast  out  1  output last.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- bypass  in  1  1 = forward the packet without a trailer; sampled on the first beat of each packet.
- pkt_count  out  16  completed packets; wraps at 16'hFFFF.

Behaviour:
- Reset: aclk single clock; areset asynchronous, active-high.
  - During and after reset: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, pkt_count=0.
  - Accumulators are cleared, state=PASS, bypass latch=0, first-beat flag=1.
- Output stage: one registered output slot. It is free when !m_axis_tvalid || m_axis_tready.
  - m_axis_* stay stable while m_axis_tvalid && !m_axis_tready.
- s_axis_tready = (state==PASS) && slot free. This is a combinational function of registered state and m_axis_tready only, never of s_axis_tvalid.
- Latency: 1 cycle from input handshake to m_axis_tvalid. Full throughput (one beat per cycle) is sustained while m_axis_tready=1.
- Data beat handshake in PASS:
  - The slot loads tdata and tkeep unchanged.
  - m_axis_tlast = s_axis_tlast && pkt_bypass, where pkt_bypass = bypass if first beat, else the latched value.
  - On the first beat, bypass is latched and the first-beat flag is cleared.
- Accumulation, on every accepted beat where pkt_bypass=0:
  - byte_cnt += popcount(tkeep), saturating at 16'hFFFF.
  - csum = (csum + sum of kept bytes, zero-extended) mod 2^16.
  - Bytes with tkeep=0 contribute nothing.
- Transitions on an accepted tlast beat:
  - pkt_bypass=1: stay in PASS. pkt_count increments. First-beat flag is set.
  - pkt_bypass=0: go to TRAILER. The accumulators include the final beat.
- TRAILER state:
  - s_axis_tready=0.
  - When the slot is free, load the trailer beat:
    - tdata[15:0]=csum, tdata[31:16]=byte_cnt, higher bits 0.
    - tkeep all ones, tlast=1.
  - In the same cycle: clear the accumulators, increment pkt_count, set the first-beat flag, return to PASS.
  - The trailer is presented the cycle after the last data beat leaves the slot, i.e. back-to-back when ready is held high.
- Packet boundaries:
  - Minimum inter-packet gap at the input is 1 cycle (the TRAILER cycle).
  - A beat with tkeep=0 is forwarded as-is and counted as 0 bytes.
  - tvalid low mid-packet is tolerated; state is held.
- Reset mid-packet: the output slot is dropped (m_axis_tvalid=0 immediately) and the partial packet gets no trailer. The next accepted beat is treated as a first beat.

Test Plan:
- Single beat: 32'h12345678, tkeep=4'hF, tlast=1, bypass=0, ready=1 -> out 12345678/tlast=0, then next cycle trailer 32'h00040114, tkeep=F, tlast=1; pkt_count=1.
- Partial keep: 32'hAABBCCDD, tkeep=4'b1100, tlast=1 -> data beat unchanged (tkeep=1100), then trailer 32'h00020165.
- Backpressure: 3 beats 32'hFFFFFFFF, keep F, m_axis_tready low for 3 cycles mid-packet -> no beat lost or duplicated; output stable while stalled; trailer 32'h000C0BF4; s_axis_tready=0 while the slot is full.
- Checksum wrap: 258 beats of 32'hFFFFFFFF -> trailer 32'h040803F8.
- Bypass: bypass=1 on the first beat, toggled to 0 mid-packet, 2-beat packet -> exactly 2 output beats, the second with tlast=1; no trailer; pkt_count increments.
- Reset mid-packet: assert areset after beat 1 of 3 -> m_axis_tvalid=0 asynchronously; pkt_count=0; the following single-beat packet 32'h01010101 yields trailer 32'h00040004.

Source files
------------

// File: rtl/axis_trailer_appender.sv
// axis_trailer_appender
// Forwards AXI-Stream data beats unchanged through a single registered output
// slot and, unless the packet is bypassed, appends one trailer beat carrying the
// packet's kept-byte count (saturating) and a 16-bit modular byte checksum.
module axis_trailer_appender #(
    parameter int TDATA_WIDTH = 32
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    input  logic                       bypass,
    output logic [15:0]                pkt_count
);

    localparam int KW = TDATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_PASS    = 1'b0,
        ST_TRAILER = 1'b1
    } state_t;

    // Number of qualified bytes in a beat.
    function automatic logic [15:0] popcount_f(input logic [KW-1:0] keep);
        logic [15:0] cnt;
        cnt = 16'd0;
        for (int i = 0; i < KW; i++) begin
            cnt = cnt + {15'd0, keep[i]};
        end
        return cnt;
    endfunction

    // Modulo-2^16 sum of the qualified bytes of a beat.
    function automatic logic [15:0] byte_sum_f(input logic [TDATA_WIDTH-1:0] data,
                                               input logic [KW-1:0]          keep);
        logic [15:0] sum;
        sum = 16'd0;
        for (int i = 0; i < KW; i++) begin
            if (keep[i]) begin
                sum = sum + {8'd0, data[8*i +: 8]};
            end else begin
                sum = sum;
            end
        end
        return sum;
    endfunction

    state_t                   state_q;
    logic                     first_q;
    logic                     byp_q;
    logic [15:0]              byte_cnt_q;
    logic [15:0]              csum_q;
    logic [15:0]              pkt_count_q;
    logic [TDATA_WIDTH-1:0]   m_tdata_q;
    logic [KW-1:0]            m_tkeep_q;
    logic                     m_tlast_q;
    logic                     m_tvalid_q;

    logic                     slot_free_s;
    logic                     accept_s;
    logic                     pkt_bypass_s;
    logic [16:0]              cnt_sum_s;
    logic [15:0]              byte_cnt_d;
    logic [15:0]              csum_d;
    logic [TDATA_WIDTH-1:0]   trailer_data_s;

    // Handshake qualifiers and next accumulator values for the current beat.
    always_comb begin
        slot_free_s   = !m_tvalid_q || m_axis_tready;
        s_axis_tready = (state_q == ST_PASS) && slot_free_s;
        accept_s      = s_axis_tvalid && s_axis_tready;
        if (first_q) begin
            pkt_bypass_s = bypass;
        end else begin
            pkt_bypass_s = byp_q;
        end
        cnt_sum_s = {1'b0, byte_cnt_q} + {1'b0, popcount_f(s_axis_tkeep)};
        if (cnt_sum_s[16]) begin
            byte_cnt_d = 16'hFFFF;
        end else begin
            byte_cnt_d = cnt_sum_s[15:0];
        end
        csum_d = csum_q + byte_sum_f(s_axis_tdata, s_axis_tkeep);
    end

    // Trailer beat layout: checksum in the low half-word, byte count above it.
    always_comb begin
        trailer_data_s        = {TDATA_WIDTH{1'b0}};
        trailer_data_s[15:0]  = csum_q;
        trailer_data_s[31:16] = byte_cnt_q;
    end

    // Packet FSM, accumulators, packet counter and the registered output slot.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_PASS;
            first_q     <= 1'b1;
            byp_q       <= 1'b0;
            byte_cnt_q  <= 16'd0;
            csum_q      <= 16'd0;
            pkt_count_q <= 16'd0;
            m_tdata_q   <= {TDATA_WIDTH{1'b0}};
            m_tkeep_q   <= {KW{1'b0}};
            m_tlast_q   <= 1'b0;
            m_tvalid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_PASS: begin
                    if (accept_s) begin
                        m_tdata_q  <= s_axis_tdata;
                        m_tkeep_q  <= s_axis_tkeep;
                        m_tlast_q  <= s_axis_tlast && pkt_bypass_s;
                        m_tvalid_q <= 1'b1;
                        if (first_q) begin
                            byp_q <= bypass;
                        end else begin
                            byp_q <= byp_q;
                        end
                        if (!pkt_bypass_s) begin
                            byte_cnt_q <= byte_cnt_d;
                            csum_q     <= csum_d;
                        end else begin
                            byte_cnt_q <= byte_cnt_q;
                            csum_q     <= csum_q;
                        end
                        if (s_axis_tlast) begin
                            first_q <= 1'b1;
                            if (pkt_bypass_s) begin
                                pkt_count_q <= pkt_count_q + 16'd1;
                            end else begin
                                state_q <= ST_TRAILER;
                            end
                        end else begin
                            first_q <= 1'b0;
                        end
                    end else if (m_axis_tready) begin
                        // Slot drained with nothing new to load.
                        m_tvalid_q <= 1'b0;
                    end else begin
                        m_tvalid_q <= m_tvalid_q;
                    end
                end
                ST_TRAILER: begin
                    if (slot_free_s) begin
                        m_tdata_q   <= trailer_data_s;
                        m_tkeep_q   <= {KW{1'b1}};
                        m_tlast_q   <= 1'b1;
                        m_tvalid_q  <= 1'b1;
                        byte_cnt_q  <= 16'd0;
                        csum_q      <= 16'd0;
                        pkt_count_q <= pkt_count_q + 16'd1;
                        first_q     <= 1'b1;
                        state_q     <= ST_PASS;
                    end else begin
                        state_q <= ST_TRAILER;
                    end
                end
                default: begin
                    state_q    <= ST_PASS;
                    first_q    <= 1'b1;
                    m_tvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_trailer_appender.sv
// Self-checking bench for axis_trailer_appender: directed scenarios plus
// randomized packets, compared against a packet-level reference model.
module tb_axis_trailer_appender;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        bypass;
    logic [15:0] pkt_count;

    axis_trailer_appender #(.TDATA_WIDTH(32)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .bypass        (bypass),
        .pkt_count     (pkt_count)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        b;
    } beat_t;

    beat_t       stim[$];
    logic [36:0] exp_q[$];
    logic [36:0] obs_q[$];
    int          obs_cyc[$];
    int          cyc;
    int          exp_pkts;
    int          rmode;
    int          vectors;
    int          errors;

    initial begin
        forever #5 aclk = ~aclk;
    end

    // Output-ready pattern: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (rmode == 0) m_tready = 1'b1;
            else if (rmode == 1) m_tready = ($urandom_range(0, 3) != 0);
            else m_tready = 1'b0;
        end
    end

    // Collect every output handshake with the cycle it happened in.
    always @(negedge aclk) begin
        cyc = cyc + 1;
        if (!areset && m_tvalid && m_tready) begin
            obs_q.push_back({m_tdata, m_tkeep, m_tlast});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic start_test();
        stim.delete();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    // Reference: per packet, forward beats (tlast only when bypassed) and
    // append {byte count (saturating), byte sum mod 2^16} when not bypassed.
    task automatic model_build();
        int i;
        i = 0;
        while (i < stim.size()) begin
            bit          pb;
            bit          done;
            int          cnt;
            int          sum;
            logic [31:0] w;
            logic [15:0] c16;
            pb = stim[i].b;
            done = 1'b0;
            cnt = 0;
            sum = 0;
            while (!done && i < stim.size()) begin
                exp_q.push_back({stim[i].d, stim[i].k, stim[i].l & pb});
                w = stim[i].d;
                for (int j = 0; j < 4; j++) begin
                    if (stim[i].k[j]) begin
                        cnt = cnt + 1;
                        sum = sum + int'(w[8*j +: 8]);
                    end
                end
                done = stim[i].l;
                i++;
            end
            if (done) begin
                exp_pkts++;
                c16 = (cnt > 65535) ? 16'hFFFF : cnt[15:0];
                if (!pb) exp_q.push_back({c16, sum[15:0], 4'hF, 1'b1});
            end
        end
    endtask

    // Drive stim beats; caller is aligned to 1 time unit after a rising edge.
    task automatic drive_stim(input int gap_max);
        for (int i = 0; i < stim.size(); i++) begin
            int g;
            bit rdy;
            int t;
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int j = 0; j < g; j++) begin
                s_tvalid = 1'b0;
                @(posedge aclk);
                #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = stim[i].d;
            s_tkeep  = stim[i].k;
            s_tlast  = stim[i].l;
            bypass   = stim[i].b;
            rdy = 1'b0;
            t = 0;
            while (!rdy && t < 2000) begin
                @(negedge aclk);
                rdy = s_tready;
                @(posedge aclk);
                #1;
                t++;
            end
            if (!rdy) begin
                vectors++;
                errors++;
                $display("FAIL drive_timeout: beat %0d s_axis_tready=%b, required 1", i, s_tready);
                s_tvalid = 1'b0;
                return;
            end
        end
        s_tvalid = 1'b0;
        bypass   = 1'b0;
    endtask

    task automatic wait_out();
        for (int c = 0; c < 5000 && obs_q.size() < exp_q.size(); c++) @(posedge aclk);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #2;
        vectors++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", {m_tvalid, m_tdata, m_tkeep, m_tlast});
        end
        vectors++;
        if (pkt_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_pkt_count: got %h, required 0", pkt_count);
        end
        areset = 1'b0;
        @(negedge aclk);
        vectors++;
        if ({m_tvalid, s_tready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_after: m_tvalid,s_tready=%b, required 01", {m_tvalid, s_tready});
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_single();
        int acc_cyc;
        start_test();
        stim.push_back(beat_t'{32'h12345678, 4'hF, 1'b1, 1'b0});
        model_build();
        drive_stim(0);
        acc_cyc = cyc;
        wait_out();
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL single_len: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (obs_q.size() < 2 || obs_q[1][36:5] !== 32'h00040114) begin
            errors++;
            $display("FAIL single_trailer: got %h, required 00040114", (obs_q.size() > 1) ? obs_q[1][36:5] : 32'h0);
        end
        vectors++;
        if (obs_cyc.size() < 2 || obs_cyc[0] !== acc_cyc + 1 || obs_cyc[1] !== acc_cyc + 2) begin
            errors++;
            $display("FAIL single_latency: accept cycle %0d, output cycles %p, required next two cycles", acc_cyc, obs_cyc);
        end
        vectors++;
        if (pkt_count !== exp_pkts[15:0]) begin
            errors++;
            $display("FAIL single_pkt_count: got %0d, required %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_partial();
        start_test();
        stim.push_back(beat_t'{32'hAABBCCDD, 4'b1100, 1'b1, 1'b0});
        model_build();
        drive_stim(0);
        wait_out();
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL partial_len: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL partial_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (obs_q.size() < 2 || obs_q[1][36:5] !== 32'h00020165) begin
            errors++;
            $display("FAIL partial_trailer: got %h, required 00020165", (obs_q.size() > 1) ? obs_q[1][36:5] : 32'h0);
        end
    endtask

    task automatic test_backpressure();
        start_test();
        for (int i = 0; i < 3; i++) stim.push_back(beat_t'{32'hFFFFFFFF, 4'hF, (i == 2), 1'b0});
        model_build();
        fork
            drive_stim(0);
            begin
                logic [36:0] snap;
                int t;
                t = 0;
                while (!m_tvalid && t < 100) begin
                    @(negedge aclk);
                    t++;
                end
                rmode = 2;
                @(negedge aclk);
                snap = {m_tdata, m_tkeep, m_tlast};
                vectors++;
                if (s_tready !== 1'b0 || m_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_tready: s_tready,m_tvalid=%b%b, required 01", s_tready, m_tvalid);
                end
                for (int s = 0; s < 2; s++) begin
                    @(negedge aclk);
                    vectors++;
                    if ({m_tdata, m_tkeep, m_tlast} !== snap || m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_stable: got %h v=%b rdy=%b, required %h v=1 rdy=0",
                                 {m_tdata, m_tkeep, m_tlast}, m_tvalid, s_tready, snap);
                    end
                end
                rmode = 0;
            end
        join
        wait_out();
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL bp_len: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (obs_q.size() < 4 || obs_q[3][36:5] !== 32'h000C0BF4) begin
            errors++;
            $display("FAIL bp_trailer: got %h, required 000C0BF4", (obs_q.size() > 3) ? obs_q[3][36:5] : 32'h0);
        end
    endtask

    task automatic test_wrap();
        int errs_before;
        start_test();
        for (int i = 0; i < 258; i++) stim.push_back(beat_t'{32'hFFFFFFFF, 4'hF, (i == 257), 1'b0});
        model_build();
        drive_stim(0);
        wait_out();
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL wrap_len: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        errs_before = errors;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i] && errors - errs_before < 5) begin
                errors++;
                $display("FAIL wrap_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (obs_q.size() < 259 || obs_q[258][36:5] !== 32'h040803F8) begin
            errors++;
            $display("FAIL wrap_trailer: got %h, required 040803F8", (obs_q.size() > 258) ? obs_q[258][36:5] : 32'h0);
        end
    endtask

    task automatic test_bypass();
        start_test();
        stim.push_back(beat_t'{32'hCAFEF00D, 4'hF, 1'b0, 1'b1});
        stim.push_back(beat_t'{32'h0BADBEEF, 4'h3, 1'b1, 1'b0});
        model_build();
        drive_stim(0);
        wait_out();
        vectors++;
        if (obs_q.size() !== 2) begin
            errors++;
            $display("FAIL bypass_len: got %0d beats, required 2", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bypass_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (pkt_count !== exp_pkts[15:0]) begin
            errors++;
            $display("FAIL bypass_pkt_count: got %0d, required %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_back_to_back();
        start_test();
        for (int p = 0; p < 3; p++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) stim.push_back(beat_t'{$urandom(), 4'hF, (i == len - 1), 1'b0});
        end
        model_build();
        drive_stim(0);
        wait_out();
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_len: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < obs_cyc.size(); i++) begin
            vectors++;
            if (obs_cyc[i] !== obs_cyc[i-1] + 1) begin
                errors++;
                $display("FAIL b2b_gap%0d: output cycle %0d, required %0d", i, obs_cyc[i], obs_cyc[i-1] + 1);
            end
        end
    endtask

    task automatic test_random();
        start_test();
        for (int p = 0; p < 25; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++)
                stim.push_back(beat_t'{$urandom(), 4'($urandom_range(0, 15)), (i == len - 1), 1'($urandom_range(0, 1))});
        end
        model_build();
        rmode = 1;
        drive_stim(2);
        wait_out();
        rmode = 0;
        repeat (3) @(posedge aclk);
        #1;
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_len: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (pkt_count !== exp_pkts[15:0]) begin
            errors++;
            $display("FAIL rand_pkt_count: got %0d, required %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_reset_mid();
        start_test();
        s_tvalid = 1'b1;
        s_tdata  = 32'h11223344;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b0;
        bypass   = 1'b0;
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        vectors++;
        if (m_tvalid !== 1'b0 || pkt_count !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_async: m_tvalid=%b pkt_count=%0d, required 0 and 0", m_tvalid, pkt_count);
        end
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_pkts = 0;
        start_test();
        stim.push_back(beat_t'{32'h01010101, 4'hF, 1'b1, 1'b0});
        model_build();
        @(posedge aclk);
        #1;
        drive_stim(0);
        wait_out();
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rstmid_len: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rstmid_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (obs_q.size() < 2 || obs_q[1][36:5] !== 32'h00040004) begin
            errors++;
            $display("FAIL rstmid_trailer: got %h, required 00040004", (obs_q.size() > 1) ? obs_q[1][36:5] : 32'h0);
        end
        vectors++;
        if (pkt_count !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_pkt_count: got %0d, required 1", pkt_count);
        end
    endtask

    initial begin
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = 32'd0;
        s_tkeep  = 4'd0;
        s_tlast  = 1'b0;
        bypass   = 1'b0;
        rmode    = 0;
        vectors  = 0;
        errors   = 0;
        exp_pkts = 0;
        test_reset();
        test_single();
        test_partial();
        test_backpressure();
        test_wrap();
        test_bypass();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
